// File: rtl/param_seq_detector.sv
// Serial bit-sequence detector with a run-time loadable pattern, per-cycle
// overlap/non-overlap selection and a saturating match counter.
module param_seq_detector #(
  parameter int unsigned               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]        PATTERN = 4'b1101,
  parameter int unsigned               CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               x_i,
  input  logic               ovl_i,
  input  logic               load_i,
  input  logic [PAT_LEN-1:0] pat_i,
  input  logic               clr_cnt_i,
  output logic               y_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               cnt_sat_o
);

  localparam int unsigned FillW = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_LEN);
  localparam logic [FillW-1:0] FillLast = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic               accept;
  logic [PAT_LEN-1:0] nxt;
  logic               match;

  // Match decode: the shifted history must equal the pattern and be fully populated.
  always_comb begin
    accept = en_i && !load_i;
    nxt    = {hist_q[PAT_LEN-2:0], x_i};
    match  = accept && (nxt == pat_q) && (fill_q >= FillLast);
  end

  // Next-state for pattern, history and fill; Load restarts detection and wins over En.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    y_d    = match;
    if (load_i) begin
      pat_d  = pat_i;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = nxt;
      if (match && !ovl_i) begin
        // Non-overlap: bits of this match cannot seed the next one.
        fill_d = '0;
      end else if (fill_q != FillFull) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Next-state for the saturating counter; a clear beats a coincident match.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (match && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = &cnt_d;
  end

  // Detection state and match pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
    end
  end

  // Match counter and saturation flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign y_o         = y_q;
  assign match_cnt_o = cnt_q;
  assign cnt_sat_o   = sat_q;

endmodule
